// File: rtl/sync_conditioner.sv
// sync_conditioner: per-channel sync synchroniser, activity/polarity detection and lock qualification
module sync_conditioner #(
  parameter int NUM_CH       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int WINDOW_LOG2  = 16,
  parameter int LOSS_TIMEOUT = 262143,
  parameter int LOCK_COUNT   = 2
) (
  input  logic              clk_50mhz_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] sync_in,
  input  logic              force_internal,
  output logic [NUM_CH-1:0] sync_out,
  output logic [NUM_CH-1:0] sync_x_out,
  output logic [NUM_CH-1:0] polarity_out,
  output logic [NUM_CH-1:0] locked_out,
  output logic [NUM_CH-1:0] signal_present_out
);
  localparam int AW = $clog2(LOSS_TIMEOUT + 1);
  localparam int HW = WINDOW_LOG2 + 1;
  localparam logic [AW-1:0] LT = AW'(LOSS_TIMEOUT);
  localparam logic [HW-1:0] HALF = HW'(1) << (WINDOW_LOG2 - 1);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  typedef enum logic [1:0] {NOSIG, ACQUIRE, LOCKED} state_t;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic win_end;
  assign win_end = &win_cnt;
  assign sync_x_out = ~sync_out;
  // shared free-running measurement window
  always_ff @(posedge clk_50mhz_in)
    win_cnt <= reset ? '0 : win_cnt + 1'b1;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sr;
    logic [AW-1:0] act_cnt, act_n;
    logic [HW-1:0] high_cnt, full;
    logic [3:0] agree, agree_n;
    logic s, tog, present, cand, cand_n, prev, prev_n, discard, discard_n, pol, pol_n, so, lock;
    state_t state, state_n;
    assign s = sr[SYNC_STAGES-1];
    assign tog = sr[SYNC_STAGES-1] ^ sr[SYNC_STAGES-2];
    assign act_n = tog ? '0 : (act_cnt == LT) ? LT : act_cnt + 1'b1;
    assign full = high_cnt + HW'(s);
    assign cand_n = (full < HALF) ? 1'b1 : (full > HALF) ? 1'b0 : cand;
    // synchroniser, activity timeout (absent until a first edge), window high count, output mux
    always_ff @(posedge clk_50mhz_in) begin
      if (reset) begin
        sr       <= '0;
        act_cnt  <= LT;
        present  <= 1'b0;
        high_cnt <= '0;
        cand     <= 1'b0;
        so       <= 1'b0;
      end else begin
        sr       <= {sr[SYNC_STAGES-2:0], sync_in[i]};
        act_cnt  <= act_n;
        present  <= act_n < LT;
        high_cnt <= win_end ? '0 : full;
        cand     <= win_end ? cand_n : cand;
        so       <= (force_internal | ~pol) ? ~s : s;
      end
    end
    // lock state register with its qualification bookkeeping
    always_ff @(posedge clk_50mhz_in) begin
      if (reset) begin
        state   <= NOSIG;
        agree   <= '0;
        prev    <= 1'b0;
        discard <= 1'b0;
        pol     <= 1'b0;
      end else begin
        state   <= state_n;
        agree   <= agree_n;
        prev    <= prev_n;
        discard <= discard_n;
        pol     <= pol_n;
      end
    end
    // next state: signal loss wins over any window decision
    always_comb begin
      state_n   = state;
      agree_n   = agree;
      prev_n    = prev;
      discard_n = discard;
      pol_n     = pol;
      if (!present) begin
        state_n = NOSIG;
        agree_n = '0;
        pol_n   = 1'b0;
      end else if (state == NOSIG) begin
        state_n   = ACQUIRE;
        agree_n   = '0;
        discard_n = 1'b1;
      end else if (win_end && state == ACQUIRE && discard) begin
        discard_n = 1'b0;
      end else if (win_end && state == ACQUIRE) begin
        agree_n = (cand_n == prev) ? agree + 4'd1 : 4'd1;
        prev_n  = cand_n;
        state_n = (agree_n == LC) ? LOCKED : ACQUIRE;
        pol_n   = (agree_n == LC) ? cand_n : pol;
      end else if (win_end && state == LOCKED && cand_n != pol) begin
        state_n   = ACQUIRE;
        agree_n   = 4'd1;
        prev_n    = cand_n;
        discard_n = 1'b0;
      end
    end
    // outputs decoded from state
    always_comb lock = (state == LOCKED);
    assign sync_out[i]           = so;
    assign polarity_out[i]       = pol;
    assign locked_out[i]         = lock;
    assign signal_present_out[i] = present;
  end
endmodule

// File: tb/tb_sync_conditioner.sv
// tb_sync_conditioner: table, hand-sequence and random stimulus checked against a behavioural model
module tb_sync_conditioner;
  localparam int NCH = 2;
  localparam int WL  = 6;
  localparam int WIN = 1 << WL;
  localparam int LT  = 300;
  localparam int LC  = 2;

  typedef struct {
    int per0; int hi0; bit neg0;
    int per1; int hi1; bit neg1;
    bit frc; int cycles;
    logic [NCH-1:0] pol; logic [NCH-1:0] lock; logic [NCH-1:0] pres;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, force_internal = 1'b0;
  logic [NCH-1:0] sync_in = '0;
  logic [NCH-1:0] sync_out, sync_x_out, polarity_out, locked_out, signal_present_out;
  int tests = 0, fails = 0, cyc = 0;

  sync_conditioner #(.NUM_CH(NCH), .SYNC_STAGES(2), .WINDOW_LOG2(WL),
                     .LOSS_TIMEOUT(LT), .LOCK_COUNT(LC)) dut (
    .clk_50mhz_in(clk), .reset(reset), .sync_in(sync_in), .force_internal(force_internal),
    .sync_out(sync_out), .sync_x_out(sync_x_out), .polarity_out(polarity_out),
    .locked_out(locked_out), .signal_present_out(signal_present_out));

  always #5 clk = ~clk;

  // model: d1/d2 hold the pin value one and two clocks back, so d2 is the synchronised level
  int p, last_tog[NCH], rl[NCH], wsum[NCH], mode[NCH];
  bit d1[NCH], d2[NCH], cand[NCH], last[NCH], skip[NCH];
  logic [NCH-1:0] e_so, e_sx, e_pol, e_lock, e_pres;
  int per[NCH], hi[NCH], ph[NCH];
  bit neg[NCH];
  vec_t tbl[6];
  int n, drop, relock;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        d1[c] = 0; d2[c] = 0; last_tog[c] = -1000000; rl[c] = 0; wsum[c] = 0; mode[c] = 0;
        cand[c] = 0; last[c] = 0; skip[c] = 0;
        e_so[c] = 0; e_pol[c] = 0; e_pres[c] = 0; e_lock[c] = 0;
      end else begin
        bit was;
        bit we;
        was = e_pres[c];
        we = (p % WIN) == WIN - 1;
        e_so[c] = force_internal ? !d2[c] : (e_pol[c] ? d2[c] : !d2[c]);
        if (d1[c] != d2[c]) last_tog[c] = p;
        e_pres[c] = (p - last_tog[c]) < LT;
        wsum[c] += int'(d2[c]);
        if (we) begin
          cand[c] = (wsum[c] * 2 < WIN) ? 1'b1 : (wsum[c] * 2 > WIN) ? 1'b0 : cand[c];
          wsum[c] = 0;
        end
        if (!was) begin
          mode[c] = 0; rl[c] = 0; e_pol[c] = 0;
        end else if (mode[c] == 0) begin
          mode[c] = 1; rl[c] = 0; skip[c] = 1;
        end else if (we && mode[c] == 1) begin
          if (skip[c]) skip[c] = 0;
          else begin
            rl[c] = (cand[c] == last[c]) ? rl[c] + 1 : 1;
            last[c] = cand[c];
            if (rl[c] >= LC) begin mode[c] = 2; e_pol[c] = cand[c]; end
          end
        end else if (we && mode[c] == 2 && cand[c] != e_pol[c]) begin
          mode[c] = 1; rl[c] = 1; last[c] = cand[c]; skip[c] = 0;
        end
        e_lock[c] = (mode[c] == 2);
        d2[c] = d1[c];
        d1[c] = sync_in[c];
      end
    end
    e_sx = ~e_so;
    p = reset ? 0 : p + 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("sync_out", sync_out, e_so);
    chk("sync_x_out", sync_x_out, e_sx);
    chk("polarity", polarity_out, e_pol);
    chk("locked", locked_out, e_lock);
    chk("present", signal_present_out, e_pres);
  endtask

  // per<0: random noise, per==0: flat level neg, else pulse train of width hi, inverted by neg
  task automatic run(int cycles);
    for (int k = 0; k < cycles; k++) begin
      for (int c = 0; c < NCH; c++) begin
        sync_in[c] = (per[c] < 0) ? 1'($urandom_range(0, 1)) :
                     (per[c] == 0) ? neg[c] : (((ph[c] % per[c]) < hi[c]) ^ neg[c]);
        ph[c]++;
      end
      tick();
    end
  endtask

  initial begin
    tbl[0] = '{59, 5, 1'b0, 40, 4, 1'b1, 1'b0, 600, 2'b01, 2'b11, 2'b11};
    tbl[1] = '{59, 5, 1'b1, 40, 4, 1'b1, 1'b0, 600, 2'b00, 2'b11, 2'b11};
    tbl[2] = '{59, 5, 1'b0, 40, 4, 1'b1, 1'b1, 600, 2'b01, 2'b11, 2'b11};
    tbl[3] = '{ 0, 0, 1'b0,  0, 0, 1'b1, 1'b0, 400, 2'b00, 2'b00, 2'b00};
    tbl[4] = '{ 8, 4, 1'b0,  0, 0, 1'b0, 1'b0, 600, 2'b01, 2'b01, 2'b01};
    tbl[5] = '{30, 4, 1'b1, 50, 6, 1'b0, 1'b0, 700, 2'b10, 2'b11, 2'b11};
    for (int c = 0; c < NCH; c++) begin per[c] = 0; hi[c] = 0; neg[c] = 0; ph[c] = 0; end
    reset = 1'b1;
    run(5);
    chk("rst_sync_out", sync_out, 2'b00);
    chk("rst_sync_x", sync_x_out, 2'b11);
    chk("rst_pol", polarity_out, 2'b00);
    chk("rst_lock", locked_out, 2'b00);
    chk("rst_pres", signal_present_out, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      per[0] = tbl[i].per0; hi[0] = tbl[i].hi0; neg[0] = tbl[i].neg0;
      per[1] = tbl[i].per1; hi[1] = tbl[i].hi1; neg[1] = tbl[i].neg1;
      force_internal = tbl[i].frc;
      run(tbl[i].cycles);
      chk($sformatf("vec%0d_pol", i), polarity_out, tbl[i].pol);
      chk($sformatf("vec%0d_lock", i), locked_out, tbl[i].lock);
      chk($sformatf("vec%0d_pres", i), signal_present_out, tbl[i].pres);
    end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) begin
        per[c] = $urandom_range(6, 60);
        hi[c] = $urandom_range(1, per[c] - 1);
        neg[c] = 1'($urandom_range(0, 1));
      end
      force_internal = 1'($urandom_range(0, 1));
      run($urandom_range(200, 500));
    end
    per[0] = -1; per[1] = -1;
    run(150);
    force_internal = 1'b0;
    per[0] = 59; hi[0] = 5; neg[0] = 0; per[1] = 40; hi[1] = 4; neg[1] = 1;
    run(600);
    chk("pos_locked", {polarity_out[0], locked_out[0]}, 2'b11);
    neg[0] = 1; drop = -1; relock = -1;
    for (int k = 1; k <= 1000 && relock < 0; k++) begin
      run(1);
      if (drop < 0 && !locked_out[0]) begin
        drop = k;
        chk("flip_pol_held", polarity_out[0], 1);
      end
      if (drop >= 0 && relock < 0 && !polarity_out[0]) begin
        relock = k;
        chk("flip_relock_lock", locked_out[0], 1);
      end
    end
    chk("flip_drop_in_time", drop >= 1 && drop <= 2 * WIN + 4, 1);
    chk("flip_relock_seen", relock > drop, 1);
    per[0] = 0; neg[0] = 0;
    run(1);
    neg[0] = 1;
    run(1);
    n = 1;
    while (signal_present_out[0] && n < 3 * LT) begin run(1); n++; end
    chk("loss_time", n, LT + 2);
    chk("loss_lock_held", locked_out[0], 1);
    run(1);
    chk("loss_pol_clr", polarity_out[0], 0);
    chk("loss_lock_clr", locked_out[0], 0);
    per[0] = 59; hi[0] = 5; neg[0] = 0; ph[0] = 0;
    n = 0;
    while (!locked_out[0] && n < 1000) begin run(1); n++; end
    chk("restart_after_discard", n >= 2 * WIN && n < 1000, 1);
    chk("restart_pol", polarity_out[0], 1);
    neg[0] = 1;
    n = 0;
    while (locked_out[0] && n < 1000) begin run(1); n++; end
    run(10);
    chk("acq_unlocked", locked_out[0], 0);
    reset = 1'b1;
    run(3);
    chk("midrst_sync_out", sync_out, 2'b00);
    chk("midrst_sync_x", sync_x_out, 2'b11);
    chk("midrst_pol", polarity_out, 2'b00);
    chk("midrst_lock", locked_out, 2'b00);
    chk("midrst_pres", signal_present_out, 2'b00);
    reset = 1'b0;
    per[0] = 0; neg[0] = 0; per[1] = 0; neg[1] = 0;
    run(LT + 50);
    chk("idle_pres", signal_present_out, 2'b00);
    chk("idle_lock", locked_out, 2'b00);
    chk("idle_pol", polarity_out, 2'b00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
